// File: rtl/layer_seq_ctrl_if.sv
// layer_seq_ctrl_if: start/result strobes plus weight, FM and result memory ports.
// The sequencer uses the master view; the layer/memory side uses the slave view.
interface layer_seq_ctrl_if #(
   parameter int W_ADDR_W   = 10,
   parameter int FM_ADDR_W  = 12,
   parameter int OUT_ADDR_W = 8
);
   logic                  i_start;
   logic                  i_blk_en;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_err;
   logic                  o_w_rd_en;
   logic [W_ADDR_W-1:0]   o_w_addr;
   logic                  o_weight_en;
   logic                  o_fm_rd_en;
   logic [FM_ADDR_W-1:0]  o_fm_addr;
   logic                  o_go;
   logic                  o_out_wr_en;
   logic [OUT_ADDR_W-1:0] o_out_addr;
   logic                  o_accum;

   modport master (
      input  i_start, i_blk_en,
      output o_busy, o_done, o_err, o_w_rd_en, o_w_addr, o_weight_en,
             o_fm_rd_en, o_fm_addr, o_go, o_out_wr_en, o_out_addr, o_accum
   );

   modport slave (
      output i_start, i_blk_en,
      input  o_busy, o_done, o_err, o_w_rd_en, o_w_addr, o_weight_en,
             o_fm_rd_en, o_fm_addr, o_go, o_out_wr_en, o_out_addr, o_accum
   );
endinterface

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: per-channel weight fetch, FM stream and result-write sequencer
// for one convolutional layer. Every output is a flop; output next-values are
// derived from the next state so they line up with the state they belong to.
module layer_seq_ctrl #(
   parameter int KERNEL_SIZE = 3,
   parameter int FM_SIZE     = 8,
   parameter int IN_FM_CH    = 2,
   parameter int RES_PER_CH  = 6,
   parameter int TIMEOUT     = 1023,
   parameter int W_ADDR_W    = 10,
   parameter int FM_ADDR_W   = 12,
   parameter int OUT_ADDR_W  = 8
) (
   input logic              i_clk,
   input logic              i_rst,
   layer_seq_ctrl_if.master bus
);
   localparam int NUM_W  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int NUM_FM = FM_SIZE * FM_SIZE;
   localparam int K_W    = (NUM_W > 1)    ? $clog2(NUM_W)    : 1;
   localparam int P_W    = (NUM_FM > 1)   ? $clog2(NUM_FM)   : 1;
   localparam int C_W    = (IN_FM_CH > 1) ? $clog2(IN_FM_CH) : 1;
   localparam int R_W    = $clog2(RES_PER_CH + 1);
   localparam int T_W    = (TIMEOUT > 1)  ? $clog2(TIMEOUT)  : 1;

   localparam logic [K_W-1:0] K_LAST = K_W'(NUM_W - 1);
   localparam logic [P_W-1:0] P_LAST = P_W'(NUM_FM - 1);
   localparam logic [C_W-1:0] C_LAST = C_W'(IN_FM_CH - 1);
   localparam logic [R_W-1:0] R_FULL = R_W'(RES_PER_CH);
   localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t state_q, state_d;
   logic [C_W-1:0] c_q, c_d;
   logic [K_W-1:0] k_q, k_d;
   logic [P_W-1:0] p_q, p_d;
   logic [R_W-1:0] r_q, r_d;
   logic [T_W-1:0] to_q, to_d;

   logic busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic w_rd_en_q, w_rd_en_d, weight_en_q, weight_en_d;
   logic fm_rd_en_q, fm_rd_en_d, go_q, go_d;
   logic out_wr_en_q, out_wr_en_d, accum_q, accum_d;
   logic [W_ADDR_W-1:0]   w_addr_q, w_addr_d;
   logic [FM_ADDR_W-1:0]  fm_addr_q, fm_addr_d;
   logic [OUT_ADDR_W-1:0] out_addr_q, out_addr_d;

   logic        start_acc, tmo, wr_hit;
   logic [31:0] w_full, fm_full;

   // State, counters and registered outputs; reset aborts any run in progress.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= S_IDLE;
         c_q         <= '0;
         k_q         <= '0;
         p_q         <= '0;
         r_q         <= '0;
         to_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         w_rd_en_q   <= 1'b0;
         w_addr_q    <= '0;
         weight_en_q <= 1'b0;
         fm_rd_en_q  <= 1'b0;
         fm_addr_q   <= '0;
         go_q        <= 1'b0;
         out_wr_en_q <= 1'b0;
         out_addr_q  <= '0;
         accum_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         k_q         <= k_d;
         p_q         <= p_d;
         r_q         <= r_d;
         to_q        <= to_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         w_rd_en_q   <= w_rd_en_d;
         w_addr_q    <= w_addr_d;
         weight_en_q <= weight_en_d;
         fm_rd_en_q  <= fm_rd_en_d;
         fm_addr_q   <= fm_addr_d;
         go_q        <= go_d;
         out_wr_en_q <= out_wr_en_d;
         out_addr_q  <= out_addr_d;
         accum_q     <= accum_d;
      end
   end

   // Next state and counters; results are only counted while the layer can produce them.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      k_d       = k_q;
      p_d       = p_q;
      r_d       = r_q;
      to_d      = '0;
      start_acc = 1'b0;
      tmo       = 1'b0;
      wr_hit    = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                  bus.i_blk_en && (r_q < R_FULL);
      if (wr_hit) r_d = r_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               start_acc = 1'b1;
               state_d   = S_LOAD_W;
               c_d       = '0;
               k_d       = '0;
               r_d       = '0;
            end
         end
         S_LOAD_W: begin
            if (k_q == K_LAST) begin
               state_d = S_STREAM;
               p_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_STREAM: begin
            if (p_q == P_LAST) state_d = S_DRAIN;
            else               p_d     = p_q + 1'b1;
         end
         S_DRAIN: begin
            // The full-count check sees r one cycle after the last write.
            if (r_q == R_FULL) begin
               if (c_q == C_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD_W;
                  c_d     = c_q + 1'b1;
                  k_d     = '0;
                  r_d     = '0;
               end
            end else if (!bus.i_blk_en && (to_q == T_LAST)) begin
               tmo     = 1'b1;
               state_d = S_DONE;
            end else begin
               to_d = bus.i_blk_en ? '0 : to_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output next-values: read strobes/addresses follow the next state, go and weight-valid lag a read by one cycle.
   always_comb begin
      busy_d      = (state_d == S_LOAD_W) || (state_d == S_STREAM) || (state_d == S_DRAIN);
      done_d      = (state_d == S_DONE);
      err_d       = err_q;
      if (start_acc) err_d = 1'b0;
      if (tmo)       err_d = 1'b1;
      w_rd_en_d   = (state_d == S_LOAD_W);
      w_full      = 32'(c_d) * 32'(NUM_W) + 32'(k_d);
      w_addr_d    = w_rd_en_d ? w_full[W_ADDR_W-1:0] : '0;
      weight_en_d = w_rd_en_q;
      fm_rd_en_d  = (state_d == S_STREAM);
      fm_full     = 32'(c_d) * 32'(NUM_FM) + 32'(p_d);
      fm_addr_d   = fm_rd_en_d ? fm_full[FM_ADDR_W-1:0] : '0;
      go_d        = (state_q == S_STREAM) && (p_q == '0);
      out_wr_en_d = wr_hit;
      out_addr_d  = wr_hit ? OUT_ADDR_W'(r_q) : out_addr_q;
      accum_d     = wr_hit && (c_q != '0);
   end

   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_err       = err_q;
   assign bus.o_w_rd_en   = w_rd_en_q;
   assign bus.o_w_addr    = w_addr_q;
   assign bus.o_weight_en = weight_en_q;
   assign bus.o_fm_rd_en  = fm_rd_en_q;
   assign bus.o_fm_addr   = fm_addr_q;
   assign bus.o_go        = go_q;
   assign bus.o_out_wr_en = out_wr_en_q;
   assign bus.o_out_addr  = out_addr_q;
   assign bus.o_accum     = accum_q;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: directed checks of layer_seq_ctrl with default parameters.
// cyc counts clock edges since the start edge; outputs are sampled 1 time unit
// after each rising edge, so cyc=1 is the first cycle after start is accepted.
module tb_layer_seq_ctrl;
   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   always #5 i_clk = ~i_clk;

   layer_seq_ctrl_if bus ();
   layer_seq_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int blk_at[$];
   int w_log[$], fm_log[$], fm_cyc[$], we_cyc[$], go_cyc[$];
   int wr_addr[$], wr_acc[$], wr_cyc[$], done_cyc[$];
   logic err_at_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [38:0] outs();
      return {bus.o_busy, bus.o_done, bus.o_err, bus.o_w_rd_en, bus.o_w_addr,
              bus.o_weight_en, bus.o_fm_rd_en, bus.o_fm_addr, bus.o_go,
              bus.o_out_wr_en, bus.o_out_addr, bus.o_accum};
   endfunction

   task automatic clear();
      cyc = 0;
      w_log.delete(); fm_log.delete(); fm_cyc.delete(); we_cyc.delete(); go_cyc.delete();
      wr_addr.delete(); wr_acc.delete(); wr_cyc.delete(); done_cyc.delete();
      err_at_done = 1'b0;
   endtask

   // One clock: drive i_blk_en for the coming edge from blk_at, then log outputs.
   task automatic step();
      bus.i_blk_en = 1'b0;
      foreach (blk_at[i]) if (blk_at[i] == cyc) bus.i_blk_en = 1'b1;
      @(posedge i_clk);
      #1;
      cyc++;
      if (bus.o_w_rd_en)   w_log.push_back(int'(bus.o_w_addr));
      if (bus.o_fm_rd_en) begin
         fm_log.push_back(int'(bus.o_fm_addr));
         fm_cyc.push_back(cyc);
      end
      if (bus.o_weight_en) we_cyc.push_back(cyc);
      if (bus.o_go)        go_cyc.push_back(cyc);
      if (bus.o_out_wr_en) begin
         wr_addr.push_back(int'(bus.o_out_addr));
         wr_acc.push_back(int'(bus.o_accum));
         wr_cyc.push_back(cyc);
      end
      if (bus.o_done) begin
         done_cyc.push_back(cyc);
         err_at_done = bus.o_err;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic start_run();
      clear();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
   endtask

   initial begin
      bus.i_start  = 1'b0;
      bus.i_blk_en = 1'b0;

      // Reset state
      #1;
      chk("reset_outs", outs(), 0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      chk("idle_outs", outs(), 0);

      // Default run: 6 results per channel, 3 cycles apart, from DRAIN entry (74 / 164)
      blk_at = {74, 77, 80, 83, 86, 89, 164, 167, 170, 173, 176, 179};
      start_run();
      chk("t1_busy_rise", bus.o_busy, 1);
      chk("t1_wrd_rise", bus.o_w_rd_en, 1);
      run(184);
      chk("t1_w_count", w_log.size(), 18);
      for (int i = 0; i < w_log.size(); i++) chk($sformatf("t1_w_addr%0d", i), w_log[i], i);
      chk("t1_fm_count", fm_log.size(), 128);
      for (int i = 0; i < fm_log.size(); i++) chk($sformatf("t1_fm_addr%0d", i), fm_log[i], i);
      chk("t1_we_count", we_cyc.size(), 18);
      chk("t1_we_first", we_cyc[0], 2);
      chk("t1_we_last0", we_cyc[8], 10);
      chk("t1_fm_rise", fm_cyc[0], 10);
      chk("t1_fm_fall", fm_cyc[63], 73);
      chk("t1_go_count", go_cyc.size(), 2);
      chk("t1_go_ch0", go_cyc[0], 11);
      chk("t1_go_ch1", go_cyc[1], 101);
      chk("t1_wr_count", wr_addr.size(), 12);
      for (int i = 0; i < wr_addr.size(); i++) begin
         chk($sformatf("t1_wr_addr%0d", i), wr_addr[i], i % 6);
         chk($sformatf("t1_wr_acc%0d", i), wr_acc[i], (i >= 6) ? 1 : 0);
      end
      chk("t1_wr_lat", wr_cyc[0], 75);
      chk("t1_wr_last", wr_cyc[11], 180);
      chk("t1_done_count", done_cyc.size(), 1);
      chk("t1_done_cyc", done_cyc[0], 181);
      chk("t1_err", err_at_done, 0);
      chk("t1_busy_end", bus.o_busy, 0);

      // Early (LOAD_W) and extra results: 8 in channel 0 DRAIN, two landing in channel 1 LOAD_W
      blk_at = {3, 5, 74, 76, 78, 80, 82, 84, 86, 88, 159, 161, 163, 165, 167, 169};
      start_run();
      run(174);
      chk("t2_wr_count", wr_addr.size(), 12);
      chk("t2_wr_first", wr_cyc[0], 75);
      chk("t2_wr_addr5", wr_addr[5], 5);
      chk("t2_wr_acc5", wr_acc[5], 0);
      chk("t2_wr_addr6", wr_addr[6], 0);
      chk("t2_wr_acc6", wr_acc[6], 1);
      chk("t2_wr_addr11", wr_addr[11], 5);
      chk("t2_w_ch1", w_log[9], 9);
      chk("t2_done_cyc", done_cyc[0], 171);
      chk("t2_err", err_at_done, 0);

      // Timeout: no results at all; DRAIN entered at 74
      blk_at = {};
      start_run();
      run(1099);
      chk("t3_done_count", done_cyc.size(), 1);
      chk("t3_done_cyc", done_cyc[0], 1097);
      chk("t3_err_at_done", err_at_done, 1);
      chk("t3_err_sticky", bus.o_err, 1);
      chk("t3_no_writes", wr_addr.size(), 0);
      start_run();
      chk("t3_err_clear", bus.o_err, 0);
      chk("t3_busy_again", bus.o_busy, 1);

      // Asynchronous reset in the middle of channel 0 STREAM
      run(29);
      chk("t4_in_stream", bus.o_fm_rd_en, 1);
      #2;
      i_rst = 1'b0;
      #1;
      chk("t4_async_outs", outs(), 0);
      @(posedge i_clk);
      #1;
      chk("t4_held_outs", outs(), 0);
      @(negedge i_clk);
      i_rst = 1'b1;
      blk_at = {74, 77, 80, 83, 86, 89, 164, 167, 170, 173, 176, 179};
      start_run();
      chk("t4_w_rd", bus.o_w_rd_en, 1);
      chk("t4_w_addr0", bus.o_w_addr, 0);
      run(184);
      chk("t4_fm_addr0", fm_log[0], 0);
      chk("t4_wr_count", wr_addr.size(), 12);
      chk("t4_wr_acc0", wr_acc[0], 0);
      chk("t4_done_cyc", done_cyc[0], 181);

      // i_start held high through a whole run
      clear();
      bus.i_start = 1'b1;
      step();
      run(180);
      chk("t5_done_count", done_cyc.size(), 1);
      chk("t5_done_cyc", done_cyc[0], 181);
      chk("t5_w_count", w_log.size(), 18);
      step();
      chk("t5_idle_gap", bus.o_busy, 0);
      step();
      chk("t5_restart_busy", bus.o_busy, 1);
      chk("t5_restart_addr", bus.o_w_addr, 0);
      chk("t5_restart_rd", bus.o_w_rd_en, 1);
      bus.i_start = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Sequencer for one convolutional layer block. It fetches kernel weights from weight memory, issues the layer's weight-load strobe and `go` pulse, and streams feature-map words from FM memory. It counts result vectors from the layer's `o_en` and generates result-memory write addresses, iterating over all input channels. It sits between the weight/FM/result BRAMs and the layer datapath. Accumulation across channels is requested from the result memory through `o_accum`.

## Interface
- `KERNEL_SIZE`, default 3: kernel side. Derived `NUM_W = KERNEL_SIZE*KERNEL_SIZE` weight words per channel.
- `FM_SIZE`, default 8: FM side. Derived `NUM_FM = FM_SIZE*FM_SIZE` words per channel.
- `IN_FM_CH`, default 2: number of input channels sequenced.
- `RES_PER_CH`, default 6: result vectors expected per channel.
- `TIMEOUT`, default 1023: idle cycles tolerated while waiting for results.
- `W_ADDR_W`, default 10; `FM_ADDR_W`, default 12; `OUT_ADDR_W`, default 8: address widths.

Ports:
- `i_clk`  in  1  single clock; all logic on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_blk_en`  in  1  layer result-valid strobe, one result vector per high cycle.
- `o_busy`  out  1  high from the cycle after start is accepted until DONE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  timeout flag; sticky until the next accepted `i_start` or reset.
- `o_w_rd_en`  out  1  weight memory read enable.
- `o_w_addr`  out  `W_ADDR_W`  weight read address.
- `o_weight_en`  out  1  weight-valid strobe to the layer.
- `o_fm_rd_en`  out  1  FM memory read enable.
- `o_fm_addr`  out  `FM_ADDR_W`  FM read address.
- `o_go`  out  1  layer start pulse.
- `o_out_wr_en`  out  1  result memory write enable.
- `o_out_addr`  out  `OUT_ADDR_W`  result write address.
- `o_accum`  out  1  high when the write must add to stored data (channel > 0).

## Operation
- All outputs are registered. On reset every output is 0, the FSM is in IDLE, and all counters are 0. Reset mid-operation aborts immediately; memories are not cleaned.
- FSM states: IDLE → LOAD_W → STREAM → DRAIN → (LOAD_W for next channel | DONE) → IDLE.
- **IDLE:** when `i_start`=1, clear the channel counter `c` and `o_err`, then go to LOAD_W.
  - `i_start` is ignored in every other state.
- **LOAD_W:** hold `o_w_rd_en`=1 for `NUM_W` cycles with `o_w_addr = c*NUM_W + k`, k = 0..NUM_W-1.
  - `o_weight_en` is `o_w_rd_en` delayed one cycle, matching the 1-cycle BRAM read latency.
  - After k = NUM_W-1, go to STREAM.
- **STREAM:** hold `o_fm_rd_en`=1 for `NUM_FM` cycles with `o_fm_addr = c*NUM_FM + p`.
  - `o_go` is high for exactly one cycle, the cycle after the first FM read (aligned with the first FM data).
  - After p = NUM_FM-1, go to DRAIN.
- **DRAIN:** wait until the result count r reaches `RES_PER_CH`.
  - If r = RES_PER_CH and c < IN_FM_CH-1: c+1, go to LOAD_W.
  - If r = RES_PER_CH and c = IN_FM_CH-1: go to DONE.
  - If `TIMEOUT` consecutive cycles pass with no `i_blk_en`: set `o_err`, go to DONE.
- **Result handling**, in STREAM and DRAIN only:
  - Each `i_blk_en`=1 with r < RES_PER_CH produces `o_out_wr_en`=1 on the next cycle, with `o_out_addr`=r and `o_accum`=(c≠0). Then r increments.
  - r clears on entry to LOAD_W.
  - `i_blk_en` when r = RES_PER_CH, or in IDLE/LOAD_W/DONE, is dropped: no write, no count.
- **DONE:** `o_done`=1 and `o_busy`=0 for one cycle, then IDLE.
- Counters are sized with clog2 of their terminal counts. Address products are computed at full width, then truncated to the port width.

## Timing
- Start accepted at edge T.
  - `o_busy` and `o_w_rd_en` rise at T+1.
  - `o_w_addr` = 0..NUM_W-1 over T+1..T+NUM_W.
  - `o_weight_en` is high T+2..T+NUM_W+1.
- `o_fm_rd_en` is high T+NUM_W+1..T+NUM_W+NUM_FM.
  - The first FM read overlaps the last `o_weight_en` cycle.
- `o_go` is high only at T+NUM_W+2.
- Write latency is `i_blk_en` → `o_out_wr_en` = 1 cycle.
- A result arriving in the same cycle that r reaches RES_PER_CH−1 is still written. The state change to LOAD_W or DONE follows on the next cycle.
- `o_done` fires one cycle after the final `o_out_wr_en`. Minimum gap to the next accepted start is 1 cycle (IDLE).
- The timeout counter resets on every `i_blk_en` and on entry to DRAIN.

## Test plan
- **Default parameters, single run:** `i_start` at T, then 6 `i_blk_en` per channel, spaced 3 cycles, starting in DRAIN.
  - `o_w_addr` 0..8 then 9..17.
  - `o_fm_addr` 0..63 then 64..127.
  - 12 writes: addresses 0..5 with `o_accum`=0, then 0..5 with `o_accum`=1.
  - One `o_done`, `o_err`=0.
- **Alignment check:**
  - `o_go` is high exactly one cycle, at T+11 in channel 0.
  - `o_weight_en` is high T+2..T+10.
  - `o_fm_rd_en` rises at T+10.
- **Extra and early results:**
  - 8 `i_blk_en` in channel 0 → only 6 writes.
  - `i_blk_en` during LOAD_W → no write.
- **Timeout:** no `i_blk_en` after the channel 0 STREAM.
  - `o_err`=1 and `o_done` exactly 1023 cycles after DRAIN entry.
  - `o_err` clears on the next start.
- **Start while busy:** `i_start` held high throughout the run → exactly one sequence. A new run is accepted in the IDLE cycle after `o_done`.
- **Reset mid-STREAM:** `i_rst`=0 asynchronously → all outputs 0 immediately. After release, a fresh start runs from channel 0 with `o_w_addr`=0.
